// File: rtl/me_search_ctrl.sv
// Sequencer for the SAD motion-search datapath: primes the reference-column FIFO, streams
// candidate columns, tracks the running minimum and reports it. Optional: ME_SEARCH_CTRL_EARLY_TERM_EN.
module me_search_ctrl #(
  parameter int EDGE_LEN      = 8,
  parameter int SEARCH_COLS   = 16,
  parameter int SAD_BIT_WIDTH = 14,
  parameter int DP_LATENCY    = 1,
  parameter int COL_W         = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     col_valid_i,
  input  logic [SAD_BIT_WIDTH-1:0] msad_i,
  input  logic [3:0]               msad_idx_i,
  input  logic [SAD_BIT_WIDTH-1:0] sad_thresh_i,
  output logic                     col_req_o,
  output logic                     cur_load_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [SAD_BIT_WIDTH-1:0] best_sad_o,
  output logic [COL_W-1:0]         best_mv_x_o,
  output logic [3:0]               best_mv_y_o
);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SEARCH,
    DRAIN,
    DONE
  } state_t;

  localparam logic [COL_W-1:0] PRIME_LAST  = COL_W'(EDGE_LEN - 2);
  localparam logic [COL_W-1:0] SEARCH_LAST = COL_W'(SEARCH_COLS - 1);
  localparam logic [COL_W-1:0] CNT_ONE     = COL_W'(1);
  localparam logic [2:0]       DRAIN_LAST  = 3'(DP_LATENCY - 1);

  state_t                   state;
  logic [COL_W-1:0]         prime_cnt;
  logic [COL_W-1:0]         push_cnt;
  logic [2:0]               drain_cnt;
  logic [SAD_BIT_WIDTH-1:0] min_sad;
  logic                     col_req_q;
  logic [DP_LATENCY-1:0]    pipe_vld;
  logic [COL_W-1:0]         pipe_tag [DP_LATENCY];

  logic sample_hit;
  logic early_stop;
  logic stall;
  logic push;

  // Strictly-less compare keeps the earliest column on a tie.
  assign sample_hit = pipe_vld[DP_LATENCY-1] && (msad_i < min_sad);

`ifdef ME_SEARCH_CTRL_EARLY_TERM_EN
  logic [SAD_BIT_WIDTH-1:0] thresh_q;

  // Kills the request in the same cycle the qualifying sample arrives, so no further column is consumed.
  assign early_stop = (state == SEARCH) && sample_hit && (msad_i <= thresh_q);
`else
  logic unused_thresh;

  assign unused_thresh = ^sad_thresh_i;
  assign early_stop    = 1'b0;
`endif

  assign col_req_o = col_req_q && !early_stop;
  assign stall     = col_req_o && !col_valid_i;
  assign push      = (state == SEARCH) && col_req_o && col_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      prime_cnt   <= '0;
      push_cnt    <= '0;
      drain_cnt   <= '0;
      min_sad     <= '1;
      col_req_q   <= 1'b0;
      cur_load_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      best_sad_o  <= '0;
      best_mv_x_o <= '0;
      best_mv_y_o <= '0;
      pipe_vld    <= '0;
      for (int i = 0; i < DP_LATENCY; i++) begin
        pipe_tag[i] <= '0;
      end
`ifdef ME_SEARCH_CTRL_EARLY_TERM_EN
      thresh_q    <= '0;
`endif
    end else begin
      // Tag pipeline mirrors the datapath latency; priming pushes never enter as valid.
      pipe_vld[0] <= push;
      pipe_tag[0] <= push_cnt;
      for (int i = 1; i < DP_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end

      if (sample_hit) begin
        min_sad     <= msad_i;
        best_sad_o  <= msad_i;
        best_mv_x_o <= pipe_tag[DP_LATENCY-1];
        best_mv_y_o <= msad_idx_i;
      end

      cur_load_o <= 1'b0;
      done_o     <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= PRIME;
            col_req_q  <= 1'b1;
            busy_o     <= 1'b1;
            cur_load_o <= 1'b1;
            err_o      <= 1'b0;
            min_sad    <= '1;
            prime_cnt  <= '0;
            push_cnt   <= '0;
            drain_cnt  <= '0;
`ifdef ME_SEARCH_CTRL_EARLY_TERM_EN
            thresh_q   <= sad_thresh_i;
`endif
          end
        end

        PRIME: begin
          if (stall) begin
            state     <= DONE;
            col_req_q <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            pipe_vld  <= '0;
          end else if (prime_cnt == PRIME_LAST) begin
            state <= SEARCH;
          end else begin
            prime_cnt <= prime_cnt + CNT_ONE;
          end
        end

        SEARCH: begin
          if (stall) begin
            state     <= DONE;
            col_req_q <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            pipe_vld  <= '0;
          end else if (early_stop) begin
            // The stop cycle itself counts as the first drain cycle.
            col_req_q <= 1'b0;
            if (DRAIN_LAST == 3'd0) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= 3'd1;
            end
          end else if (push_cnt == SEARCH_LAST) begin
            state     <= DRAIN;
            col_req_q <= 1'b0;
            drain_cnt <= '0;
          end else begin
            push_cnt <= push_cnt + CNT_ONE;
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Scoreboard bench for me_search_ctrl: directed searches push expected results, a monitor
// pops and compares them on every done_o pulse. The bench also plays the datapath.
module tb_me_search_ctrl;

  localparam int SW = 14;
  localparam int CW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          col_valid_i;
  logic [SW-1:0] msad_i;
  logic [3:0]    msad_idx_i;
  logic [SW-1:0] sad_thresh_i;
  logic          col_req_o;
  logic          cur_load_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [SW-1:0] best_sad_o;
  logic [CW-1:0] best_mv_x_o;
  logic [3:0]    best_mv_y_o;

  me_search_ctrl #(
    .EDGE_LEN     (8),
    .SEARCH_COLS  (16),
    .SAD_BIT_WIDTH(SW),
    .DP_LATENCY   (1),
    .COL_W        (CW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .col_valid_i (col_valid_i),
    .msad_i      (msad_i),
    .msad_idx_i  (msad_idx_i),
    .sad_thresh_i(sad_thresh_i),
    .col_req_o   (col_req_o),
    .cur_load_o  (cur_load_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .best_sad_o  (best_sad_o),
    .best_mv_x_o (best_mv_x_o),
    .best_mv_y_o (best_mv_y_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int cyc;
    int err;
    int sad;
    int mvx;
    int mvy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   cur_t0   = -1000;
  int   cl_count = 0;
  int   junk_sad = 1;
  int   pat_sad[16];
  int   pat_idx[16];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkReset(input string pfx);
    checkOutput({pfx, "_busy"}, int'(busy_o), 0);
    checkOutput({pfx, "_col_req"}, int'(col_req_o), 0);
    checkOutput({pfx, "_cur_load"}, int'(cur_load_o), 0);
    checkOutput({pfx, "_done"}, int'(done_o), 0);
    checkOutput({pfx, "_err"}, int'(err_o), 0);
    checkOutput({pfx, "_best_sad"}, int'(best_sad_o), 0);
    checkOutput({pfx, "_mv_x"}, int'(best_mv_x_o), 0);
    checkOutput({pfx, "_mv_y"}, int'(best_mv_y_o), 0);
  endtask

  task automatic pushExpect(input int at_cyc, input int e_err, input int e_sad,
                            input int e_mvx, input int e_mvy);
    exp_t e;
    e.cyc = at_cyc;
    e.err = e_err;
    e.sad = e_sad;
    e.mvx = e_mvx;
    e.mvy = e_mvy;
    exp_q.push_back(e);
  endtask

  // Raises start_i for cycle T0 and records the expected completion at T0+offset.
  task automatic applyStimulus(input int offset, input bit expect_done, input int e_err,
                               input int e_sad, input int e_mvx, input int e_mvy,
                               input bit hold);
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    cur_t0  = cyc;
    if (expect_done) pushExpect(cyc + offset, e_err, e_sad, e_mvx, e_mvy);
    if (!hold) begin
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
    end
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk_i);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got %0d outstanding results, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Datapath model: column c's minimum is presented at T(9+c) relative to the latest start.
  initial begin
    int col;
    msad_i     = '0;
    msad_idx_i = '0;
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      col = cyc - cur_t0 - 9;
      if (col >= 0 && col < 16) begin
        msad_i     = SW'(pat_sad[col]);
        msad_idx_i = 4'(pat_idx[col]);
      end else begin
        msad_i     = SW'(junk_sad);
        msad_idx_i = 4'd0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (cur_load_o) cl_count++;
      if (done_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done_o=1 at cycle %0d, expected no completion", cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_cycle", cyc, e.cyc);
          checkOutput("err", int'(err_o), e.err);
          checkOutput("best_sad", int'(best_sad_o), e.sad);
          checkOutput("best_mv_x", int'(best_mv_x_o), e.mvx);
          checkOutput("best_mv_y", int'(best_mv_y_o), e.mvy);
          checkOutput("busy_at_done", int'(busy_o), 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    col_valid_i  = 1'b1;
    sad_thresh_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checkReset("reset");
    rst_i = 1'b0;

    $display("[TB] monotonic SAD search");
    for (int c = 0; c < 16; c++) begin
      pat_sad[c] = 100 - c;
      pat_idx[c] = 3;
    end
    applyStimulus(25, 1'b1, 0, 85, 15, 3, 1'b0);
    waitDone(60);
    repeat (3) @(posedge clk_i);

    $display("[TB] stall during search");
    for (int c = 0; c < 16; c++) begin
      pat_sad[c] = 50 + c;
      pat_idx[c] = 2;
    end
    applyStimulus(13, 1'b1, 1, 50, 0, 2, 1'b0);
    repeat (11) @(posedge clk_i);
    #1;
    col_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    col_valid_i = 1'b1;
    checkOutput("stall_col_req_t13", int'(col_req_o), 0);
    @(posedge clk_i);
    #1;
    checkOutput("stall_col_req_t14", int'(col_req_o), 0);
    checkOutput("stall_err_held", int'(err_o), 1);
    waitDone(60);
    repeat (3) @(posedge clk_i);

    $display("[TB] tie between columns 2 and 9");
    for (int c = 0; c < 16; c++) begin
      pat_sad[c] = 200;
      pat_idx[c] = 0;
    end
    pat_sad[2] = 40;
    pat_idx[2] = 5;
    pat_sad[9] = 40;
    pat_idx[9] = 7;
    applyStimulus(25, 1'b1, 0, 40, 2, 5, 1'b0);
    waitDone(60);
    repeat (3) @(posedge clk_i);

    $display("[TB] reset in the middle of a search");
    for (int c = 0; c < 16; c++) begin
      pat_sad[c] = 100 - c;
      pat_idx[c] = 3;
    end
    applyStimulus(0, 1'b0, 0, 0, 0, 0, 1'b0);
    repeat (14) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    checkReset("midrst");
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    applyStimulus(25, 1'b1, 0, 85, 15, 3, 1'b0);
    waitDone(60);
    repeat (3) @(posedge clk_i);

    $display("[TB] start held high, back-to-back searches");
    for (int c = 0; c < 16; c++) begin
      pat_sad[c] = 50;
      pat_idx[c] = 0;
    end
    junk_sad = 50;
    cl_count = 0;
    applyStimulus(25, 1'b1, 0, 50, 0, 0, 1'b1);
    pushExpect(cur_t0 + 51, 0, 50, 0, 0);
    pushExpect(cur_t0 + 77, 0, 50, 0, 0);
    repeat (77) @(posedge clk_i);
    #1;
    start_i = 1'b0;
    waitDone(10);
    repeat (30) @(posedge clk_i);
    checkOutput("b2b_cur_load_pulses", cl_count, 3);
    checkOutput("b2b_idle_busy", int'(busy_o), 0);
    junk_sad = 1;

    $display("[TB] threshold stimulus");
    for (int c = 0; c < 16; c++) begin
      pat_sad[c] = 100;
      pat_idx[c] = 1;
    end
    pat_sad[4]   = 20;
    pat_idx[4]   = 6;
    sad_thresh_i = SW'(30);
`ifdef ME_SEARCH_CTRL_EARLY_TERM_EN
    applyStimulus(14, 1'b1, 0, 20, 4, 6, 1'b0);
`else
    applyStimulus(25, 1'b1, 0, 20, 4, 6, 1'b0);
`endif
    waitDone(60);
    repeat (5) @(posedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/me_search_ctrl.md
Name: me_search_ctrl

Overview:
- Sequencer for the SAD search datapath: FIFO reference-column shift, AD array, per-row adder trees and 16-way minimum.
- On a start command it primes the column FIFO and streams SEARCH_COLS candidate columns.
- It samples the per-column minimum SAD and row index after the datapath latency, and keeps the running best across columns.
- It reports the final best SAD and motion vector with a done pulse. It sits between the frame-level scheduler and the search datapath.

Parameters:
- EDGE_LEN, 8, block edge; number of priming columns is EDGE_LEN-1.
- SEARCH_COLS, 16, candidate horizontal positions per search.
- SAD_BIT_WIDTH, 14, width of SAD values.
- DP_LATENCY, 1, cycles from a column push to the matching msad_i/msad_idx_i being valid; legal range 1..4.
- COL_W, 5, width of column counters; must satisfy 2^COL_W > EDGE_LEN-1+SEARCH_COLS.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  start request; sampled only in IDLE.
- col_valid_i  input  1  upstream reference column present on FIFO input this cycle.
- msad_i  input  SAD_BIT_WIDTH  per-column minimum SAD from the datapath.
- msad_idx_i  input  4  row index of msad_i.
- sad_thresh_i  input  SAD_BIT_WIDTH  early-termination threshold; used only with EARLY_TERM_EN.
- col_req_o  output  1  request and consume one reference column this cycle.
- cur_load_o  output  1  one-cycle pulse to latch the current block.
- busy_o  output  1  search in progress.
- done_o  output  1  one-cycle completion pulse.
- err_o  output  1  held high with done_o when the search aborted.
- best_sad_o  output  SAD_BIT_WIDTH  best SAD of the last search.
- best_mv_x_o  output  COL_W  column of the best candidate, 0..SEARCH_COLS-1.
- best_mv_y_o  output  4  row of the best candidate.

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE.
  - All outputs 0, all counters 0.
  - Running minimum set to all-ones.
- Reset mid-search aborts immediately. No done_o is generated.
- States: IDLE, PRIME, SEARCH, DRAIN, DONE.
- IDLE:
  - start_i=1 at cycle T0 moves to PRIME at T1.
  - At the transition, clear the running minimum to all-ones and zero the push counter.
- PRIME (T1..T(EDGE_LEN-1)):
  - col_req_o=1 and busy_o=1.
  - cur_load_o=1 on the first PRIME cycle only.
  - Lasts EDGE_LEN-1 cycles, then SEARCH.
- SEARCH:
  - col_req_o=1 for SEARCH_COLS cycles.
  - The push at SEARCH cycle c is candidate column c.
  - Then DRAIN.
- DRAIN: col_req_o=0 for DP_LATENCY cycles, then DONE.
- DONE:
  - done_o=1 and busy_o=0 for one cycle, then IDLE.
  - Results are stable from the DONE cycle until the next start.
- Sampling:
  - A DP_LATENCY-deep shift register carries a valid bit plus the column tag of each SEARCH push.
  - When the tagged valid bit emerges, compare msad_i with the running minimum.
  - Update only if strictly less. On a tie the earlier column is kept.
  - The update registers msad_i, the tag and msad_idx_i into best_*_o on the next edge.
  - Priming pushes carry valid=0.
- Timing for defaults (EDGE_LEN=8, SEARCH_COLS=16, DP_LATENCY=1):
  - PRIME T1..T7, SEARCH T8..T23.
  - Column c is sampled at T(9+c). DRAIN at T24, done_o at T25.
- Stall:
  - col_valid_i=0 while col_req_o=1 is an abort.
  - Go to DONE next cycle with err_o=1.
  - best_*_o keep the values accumulated so far.
  - The pipeline valid bits are flushed.
- start_i while busy_o=1 is ignored.
- start_i in DONE is ignored. A new start needs IDLE.
- err_o is cleared at the next start.
- No wrap-around: counters saturate at their terminal counts; terminal counts are compared exactly.

Optional Feature:
- Macro: ME_SEARCH_CTRL_EARLY_TERM_EN.
- Defined:
  - After any sampling update, if the new best ≤ sad_thresh_i, stop requesting columns.
  - Enter DRAIN for the DP_LATENCY in-flight samples, which are still compared, then DONE with err_o=0.
  - sad_thresh_i is sampled at start.
- Not defined: sad_thresh_i is ignored and the search always runs all SEARCH_COLS columns.

Test Plan:
- Monotonic SAD: msad_i = 100 - column (columns 0..15), msad_idx_i = 3 -> done_o at T25, best_sad_o=85, best_mv_x_o=15, best_mv_y_o=3, err_o=0.
- Tie: msad_i=40 at columns 2 and 9, all others 200, idx 5 and 7 respectively -> best_sad_o=40, best_mv_x_o=2, best_mv_y_o=5.
- Stall: col_valid_i=0 at T12 -> done_o at T13, err_o=1, busy_o=0 at T13, col_req_o=0 from T13.
- Reset at T15 during SEARCH -> all outputs 0 immediately. start at T20 completes normally with done_o at T20+25.
- start_i held high continuously with constant msad_i=50 -> searches back to back with done_o every 26 cycles; cur_load_o pulses once per search; best_sad_o=50, best_mv_x_o=0.
- EARLY_TERM_EN, sad_thresh_i=30, msad_i=20 at column 4 (else 100), DP_LATENCY=1:
  - Last push at T12, DRAIN T13, done_o at T14.
  - best_sad_o=20, best_mv_x_o=4.
  - Without the macro, the same stimulus gives done_o at T25 with the same result.
